// File: rtl/pingpong_buffer_pkg.sv
// pingpong_buffer_pkg: shared types and limits for the double-buffered operand fetch
package pingpong_buffer_pkg;
    localparam int ADDR_BITS = 64;
    localparam int LENGTH_BITS = 5;
    localparam int REPEAT_BITS = 12;
    localparam int MAX_OUTSTANDING = 8;
    typedef enum logic [1:0] {BANK_FREE, BANK_FILLING, BANK_DRAINING} bank_state_t;
    typedef enum logic {MODE_RR, MODE_BCAST} mode_e;
    typedef struct packed {
        logic [ADDR_BITS-1:0] address;
        logic [LENGTH_BITS-1:0] length;
        logic [REPEAT_BITS-1:0] repeats;
        mode_e mode;
    } bank_desc_t;
endpackage

// File: rtl/pingpong_memory_buffer_bank.sv
// operand_bank: operand storage written one memory beat at a time, read one vector at a time
module operand_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int N = 4,
    parameter int M = 16,
    parameter int P = 4
) (
    input  logic clk,
    input  logic write_enable,
    input  logic [$clog2(M*N/P)-1:0] write_beat,
    input  logic [P*DATA_WIDTH-1:0] write_data,
    input  logic [$clog2(M)-1:0] read_vector,
    output logic [N*DATA_WIDTH-1:0] read_data
);
    localparam int BPV = N / P;
    localparam int BEATS = M * BPV;
    localparam int BEAT_IDX = $clog2(BEATS);
    logic [P*DATA_WIDTH-1:0] mem [BEATS];
    always_ff @(posedge clk)
        if (write_enable) mem[write_beat] <= write_data;
    for (genvar j = 0; j < BPV; j++) begin : g_rd
        assign read_data[j*P*DATA_WIDTH +: P*DATA_WIDTH] = mem[BEAT_IDX'(32'(read_vector) * BPV + j)];
    end
endmodule

// File: rtl/pingpong_memory_buffer.sv
// pingpong_memory_buffer: two operand banks; one fills from memory while the other replays to the processors
module pingpong_memory_buffer
    import pingpong_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N = 4,
    parameter int M = 16,
    parameter int P = 4,
    parameter int NUM_PROCESSORS = 4,
    parameter int ID_BITS = $clog2(NUM_PROCESSORS),
    parameter int MEMORY_ADDRESS_BITS = ADDR_BITS,
    parameter int LEN_BITS = $clog2(M + 1),
    parameter int REP_BITS = REPEAT_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic instruction_valid,
    output logic instruction_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0] address_input,
    input  logic [LEN_BITS-1:0] length_input,
    input  logic [REP_BITS-1:0] repeats_input,
    input  logic mode_input,
    output logic memory_req_valid,
    input  logic memory_req_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0] memory_address,
    input  logic memory_rsp_valid,
    input  logic [P*DATA_WIDTH-1:0] memory_data,
    output logic processor_input_valid,
    input  logic [NUM_PROCESSORS-1:0] processor_input_ready,
    output logic [ID_BITS-1:0] processor_input_id,
    output logic [N*DATA_WIDTH-1:0] processor_input_data,
    output logic last
);
    localparam int BPV = N / P;
    localparam int BEATS = M * BPV;
    localparam int BEAT_IDX = $clog2(BEATS);
    localparam int BEAT_CNT = $clog2(BEATS + 1);
    localparam int VEC_IDX = $clog2(M);
    localparam int OUT_BITS = $clog2(MAX_OUTSTANDING + 1);

    bank_desc_t desc [2];
    bank_state_t state [2];
    logic [1:0] alloc, issuing, filling, write_enable;
    logic head, fill_bank, rsp_bank, fill_any, alloc_bank;
    logic [BEAT_CNT-1:0] req_cnt [2];
    logic [BEAT_CNT-1:0] beats [2];
    logic [OUT_BITS-1:0] outstanding;
    logic [LEN_BITS-1:0] d_vec;
    logic [ID_BITS-1:0] d_id;
    logic [REP_BITS-1:0] d_pass;
    logic [N*DATA_WIDTH-1:0] read_data [2];
    logic req_fire, rsp_take, keep, eligible, bcast, fire, vec_done, rep_end, final_xfer;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            issuing[i] = alloc[i] && 32'(req_cnt[i]) < 32'(desc[i].length) * BPV;
            filling[i] = alloc[i] && 32'(beats[i]) < 32'(desc[i].length) * BPV;
            state[i] = !alloc[i] ? BANK_FREE : filling[i] ? BANK_FILLING : BANK_DRAINING;
        end
    end

    // head is always the oldest loaded bank, so fill and response routing both prefer it
    assign instruction_ready = state[0] == BANK_FREE || state[1] == BANK_FREE;
    assign alloc_bank = state[0] != BANK_FREE;
    assign keep = instruction_valid && instruction_ready && length_input != '0 && repeats_input != '0;
    assign fill_any = issuing[head] || issuing[~head];
    assign fill_bank = issuing[head] ? head : ~head;
    assign rsp_bank = filling[head] ? head : ~head;
    assign memory_req_valid = fill_any && 32'(outstanding) < MAX_OUTSTANDING;
    assign memory_address = fill_any ? MEMORY_ADDRESS_BITS'(desc[fill_bank].address + ADDR_BITS'(32'(req_cnt[fill_bank]) * P)) : '0;
    assign req_fire = memory_req_valid && memory_req_ready;
    assign rsp_take = memory_rsp_valid && outstanding != '0 && filling != 2'b00;
    assign write_enable = {rsp_take && rsp_bank, rsp_take && !rsp_bank};

    assign eligible = d_pass != '0 || 32'(beats[head]) >= (32'(d_vec) + 1) * BPV;
    assign processor_input_valid = alloc[head] && eligible;
    assign bcast = desc[head].mode == MODE_BCAST;
    assign processor_input_id = processor_input_valid && !bcast ? d_id : '0;
    assign processor_input_data = processor_input_valid ? read_data[head] : '0;
    assign last = processor_input_valid && 32'(d_vec) + 1 == 32'(desc[head].length);
    assign fire = processor_input_valid && (bcast ? &processor_input_ready : processor_input_ready[d_id]);
    assign vec_done = fire && (bcast || 32'(d_id) == NUM_PROCESSORS - 1);
    assign rep_end = vec_done && last;
    assign final_xfer = rep_end && 32'(d_pass) + 1 == 32'(desc[head].repeats);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        operand_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .M(M), .P(P)) u_bank (
            .clk(clk),
            .write_enable(write_enable[b]),
            .write_beat(beats[b][BEAT_IDX-1:0]),
            .write_data(memory_data),
            .read_vector(d_vec[VEC_IDX-1:0]),
            .read_data(read_data[b])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc <= '0;
            head <= 1'b0;
            outstanding <= '0;
            d_vec <= '0;
            d_id <= '0;
            d_pass <= '0;
            req_cnt <= '{default: '0};
            beats <= '{default: '0};
        end else begin
            outstanding <= outstanding + OUT_BITS'(req_fire) - OUT_BITS'(rsp_take);
            if (req_fire) req_cnt[fill_bank] <= req_cnt[fill_bank] + 1'b1;
            if (rsp_take) beats[rsp_bank] <= beats[rsp_bank] + 1'b1;
            if (fire) begin
                d_id <= vec_done ? '0 : d_id + 1'b1;
                if (vec_done) d_vec <= rep_end ? '0 : d_vec + 1'b1;
                if (rep_end) d_pass <= final_xfer ? '0 : d_pass + 1'b1;
            end
            if (final_xfer) begin
                alloc[head] <= 1'b0;
                head <= ~head;
            end else if (keep && !alloc[head])
                head <= alloc_bank;
            if (keep) begin
                alloc[alloc_bank] <= 1'b1;
                desc[alloc_bank] <= '{address: ADDR_BITS'(address_input), length: LENGTH_BITS'(length_input),
                                      repeats: REPEAT_BITS'(repeats_input), mode: mode_e'(mode_input)};
                req_cnt[alloc_bank] <= '0;
                beats[alloc_bank] <= '0;
            end
        end
    end
endmodule
